// File: rtl/usr_pkg.sv
// Shared definitions for the shift sequencer.
// Holds the shift-register mode codes and the sequencer FSM state encoding.
package usr_pkg;

    // Mode codes understood by universal_shift_register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/universal_shift_register.sv
// N-bit universal shift register.
// Supports hold, shift right, shift left and parallel load, selected by mode.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic [N-1:0] parallel_in,
    input  logic         serial_in_left,
    input  logic         serial_in_right,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Select the next register value from the requested mode
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        q_d = q_q;
        case (mode)
            MODE_SHR:  q_d = {serial_in_left, q_q[N-1:1]};
            MODE_SHL:  q_d = {q_q[N-2:0], serial_in_right};
            MODE_LOAD: q_d = parallel_in;
            default:   q_d = q_q;
        endcase
    end

    // Register storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments in clocked blocks avoid simulation races between registers.
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Shift sequencer: accepts a job (word, direction, count, fill bit), loads the
// word into a universal shift register, shifts it the requested number of times
// (clamped to N) and pulses done. A job can be cancelled with abort.
module shift_sequencer
    import usr_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [N-1:0]  data_in,
    input  logic          dir,
    input  logic [CW-1:0] shift_count,
    input  logic          fill_bit,
    input  logic          abort,
    output logic [1:0]    mode,
    output logic [N-1:0]  q,
    output logic          serial_out,
    output logic          serial_valid,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] N_CW = CW'(N);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          fill_q, fill_d;
    logic [N-1:0]  data_q, data_d;
    logic          accept;

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign accept      = start_valid && start_ready;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job latches and shift down-counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            fill_q <= fill_d;
            data_q <= data_d;
        end
    end

    // Capture the job on acceptance, count down while shifting
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        fill_d = fill_q;
        data_d = data_q;
        if (accept) begin
            dir_d  = dir;
            fill_d = fill_bit;
            data_d = data_in;
            cnt_d  = (shift_count > N_CW) ? N_CW : shift_count;
        end else if (state_q == ST_SHIFT && !abort) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Next-state logic; abort outranks every transition out of a busy state
    always_comb begin
        state_d = state_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = ST_LOAD;
                ST_LOAD:  state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
                ST_SHIFT: if (cnt_q <= CW'(1)) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: register mode, serial tap and completion pulse
    always_comb begin
        mode         = MODE_HOLD;
        done         = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (!abort) mode = MODE_LOAD;
            end
            ST_SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = dir_q ? q[N-1] : q[0];
                if (!abort) mode = dir_q ? MODE_SHL : MODE_SHR;
            end
            ST_DONE: begin
                done = !abort;
            end
            default: begin
                mode = MODE_HOLD;
            end
        endcase
    end

    // The fill bit enters whichever end is vacated; the register ignores the other input
    universal_shift_register #(.N(N)) u_usr (
        .clk             (clk),
        .rst_n           (reset),
        .mode            (mode),
        .parallel_in     (data_q),
        .serial_in_left  (fill_q),
        .serial_in_right (fill_q),
        .q               (q)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a scoreboard of expected serial bits
// and register snapshots, pushed when a job is issued and popped per SHIFT cycle.
module tb_shift_sequencer;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [N-1:0]  data_in;
    logic          dir;
    logic [CW-1:0] shift_count;
    logic          fill_bit;
    logic          abort;
    logic [1:0]    mode;
    logic [N-1:0]  q;
    logic          serial_out;
    logic          serial_valid;
    logic          busy;
    logic          done;

    typedef struct {
        logic         sbit;
        logic [N-1:0] qv;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [N-1:0] qf;

    always #5 clk = ~clk;

    shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .data_in      (data_in),
        .dir          (dir),
        .shift_count  (shift_count),
        .fill_bit     (fill_bit),
        .abort        (abort),
        .mode         (mode),
        .q            (q),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Start a new cycle: 1 ns after the rising edge, with one-cycle pulses cleared
    task automatic cyc();
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        abort       = 1'b0;
    endtask

    // Let combinational outputs settle before sampling (well before the next edge)
    task automatic settle();
        #3;
    endtask

    // Issue one job and follow it to completion, checking every cycle
    task automatic run_job(input string name, input logic [N-1:0] d, input logic dr,
                           input logic [CW-1:0] sc, input logic fb, output logic [N-1:0] q_final);
        int           c;
        int           shifts;
        bit           seen_done;
        logic [N-1:0] qv;
        exp_t         e;
        c  = (int'(sc) > N) ? N : int'(sc);
        qv = d;
        for (int i = 0; i < c; i++) begin
            e.sbit = dr ? qv[N-1] : qv[0];
            e.qv   = qv;
            sb.push_back(e);
            qv = dr ? {qv[N-2:0], fb} : {fb, qv[N-1:1]};
        end
        // cycle 0: acceptance
        cyc();
        start_valid = 1'b1;
        data_in     = d;
        dir         = dr;
        shift_count = sc;
        fill_bit    = fb;
        settle();
        check({name, " ready"}, start_ready, 1);
        check({name, " no_done_idle"}, done, 0);
        check({name, " idle_mode"}, mode, 2'b00);
        // cycle 1: LOAD, inputs scrambled to prove the job was latched
        cyc();
        data_in     = ~d;
        dir         = ~dr;
        fill_bit    = ~fb;
        shift_count = '0;
        settle();
        check({name, " load_mode"}, mode, 2'b11);
        check({name, " load_busy"}, busy, 1);
        check({name, " load_valid"}, serial_valid, 0);
        shifts    = 0;
        seen_done = 0;
        for (int k = 2; k < 2 + N + 4 && !seen_done; k++) begin
            cyc();
            settle();
            if (done) begin
                seen_done = 1;
                check({name, " done_cycle"}, k, 2 + c);
                check({name, " shift_count"}, shifts, c);
                check({name, " done_mode"}, mode, 2'b00);
                check({name, " final_q"}, q, qv);
                check({name, " sb_empty"}, sb.size(), 0);
            end else if (serial_valid) begin
                if (sb.size() == 0) begin
                    check({name, " extra_shift"}, shifts + 1, c);
                end else begin
                    e = sb.pop_front();
                    check({name, " serial_out"}, serial_out, e.sbit);
                    check({name, " shift_q"}, q, e.qv);
                    check({name, " shift_mode"}, mode, dr ? 2'b10 : 2'b01);
                end
                shifts++;
            end else begin
                check({name, " stall"}, serial_valid, 1);
            end
        end
        if (!seen_done) check({name, " done_timeout"}, done, 1);
        sb.delete();
        q_final = q;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
        data_in     = '0;
        dir         = 1'b0;
        shift_count = '0;
        fill_bit    = 1'b0;
        #2;
        check("rst q", q, 0);
        check("rst mode", mode, 2'b00);
        check("rst done", done, 0);
        check("rst serial_valid", serial_valid, 0);
        check("rst busy", busy, 0);
        check("rst start_ready", start_ready, 1);
        #10 rst_n = 1'b1;

        // Right shift, left shift, load-only and clamped jobs back to back
        run_job("shr", 4'b1010, 1'b0, 3'd4, 1'b0, qf);
        check("shr q_const", qf, 4'b0000);
        run_job("shl", 4'b1100, 1'b1, 3'd2, 1'b1, qf);
        check("shl q_const", qf, 4'b0011);
        run_job("load_only", 4'b0110, 1'b0, 3'd0, 1'b0, qf);
        check("load_only q_const", qf, 4'b0110);
        run_job("clamp", 4'b0110, 1'b1, 3'd7, 1'b1, qf);
        check("clamp q_const", qf, 4'b1111);

        // Idle after DONE: pulse is gone and q held; abort in IDLE does nothing
        cyc();
        settle();
        check("idle done_low", done, 0);
        check("idle busy", busy, 0);
        check("idle q_hold", q, 4'b1111);
        cyc();
        abort = 1'b1;
        settle();
        check("idle_abort busy", busy, 0);
        check("idle_abort ready", start_ready, 1);
        check("idle_abort mode", mode, 2'b00);
        cyc();
        settle();
        check("idle_abort q", q, 4'b1111);

        // Abort in the second SHIFT cycle; start_valid while busy is ignored
        cyc();
        start_valid = 1'b1;
        data_in     = 4'b1010;
        dir         = 1'b0;
        shift_count = 3'd4;
        fill_bit    = 1'b0;
        settle();
        check("abort accept", start_ready, 1);
        cyc();
        settle();
        check("abort load_mode", mode, 2'b11);
        cyc();
        start_valid = 1'b1;
        settle();
        check("abort shift1 mode", mode, 2'b01);
        check("abort shift1 ready", start_ready, 0);
        check("abort shift1 serial", serial_out, 0);
        cyc();
        start_valid = 1'b1;
        abort       = 1'b1;
        settle();
        check("abort cycle mode", mode, 2'b00);
        check("abort cycle done", done, 0);
        check("abort cycle q", q, 4'b0101);
        cyc();
        settle();
        check("after_abort busy", busy, 0);
        check("after_abort done", done, 0);
        check("after_abort q", q, 4'b0101);
        check("after_abort ready", start_ready, 1);
        cyc();
        settle();
        check("no_queue busy", busy, 0);
        check("no_queue done", done, 0);
        check("no_queue q", q, 4'b0101);

        // Reset pulled low mid-SHIFT takes effect immediately
        cyc();
        start_valid = 1'b1;
        data_in     = 4'b1010;
        dir         = 1'b0;
        shift_count = 3'd4;
        fill_bit    = 1'b0;
        settle();
        cyc();
        settle();
        cyc();
        settle();
        check("mid_rst in_shift", serial_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst q", q, 0);
        check("mid_rst busy", busy, 0);
        check("mid_rst ready", start_ready, 1);
        check("mid_rst mode", mode, 2'b00);
        check("mid_rst done", done, 0);
        check("mid_rst serial_valid", serial_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Jobs resume right after reset and run back to back without a gap
        run_job("post_rst", 4'b0011, 1'b1, 3'd1, 1'b0, qf);
        check("post_rst q_const", qf, 4'b0110);
        run_job("b2b", 4'b1001, 1'b0, 3'd3, 1'b1, qf);
        check("b2b q_const", qf, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
